// File: rtl/quad_spi_seq_arb.sv
// Round-robin sequencer that walks each granted flash transaction through CMD/ADDR/DUMMY/DATA.
// Optional build macro QSPI_SEQ_QUAD_ADDR_EN drives XIP ADDR and DUMMY phases on four lanes.
module quad_spi_seq_arb #(
   parameter int CS_IDLE_MIN = 2,
   parameter int DUMMY_W     = 4,
   parameter int LEN_W       = 6
) (
   input  logic               pclk,
   input  logic               rst,
   input  logic               xip_req,
   input  logic [23:0]        xip_addr,
   input  logic [LEN_W-1:0]   xip_len,
   input  logic [7:0]         xip_opcode,
   input  logic [DUMMY_W-1:0] xip_dummy,
   output logic               xip_gnt,
   output logic               xip_done,
   input  logic               apb_req,
   input  logic [7:0]         apb_cmd,
   input  logic [23:0]        apb_addr,
   input  logic               apb_addr_en,
   input  logic [DUMMY_W-1:0] apb_dummy,
   input  logic [LEN_W-1:0]   apb_len,
   input  logic               apb_rd,
   output logic               apb_gnt,
   output logic               apb_done,
   output logic               sh_valid,
   input  logic               sh_ready,
   input  logic               sh_done,
   output logic [1:0]         sh_phase,
   output logic [7:0]         sh_cnt,
   output logic               sh_quad,
   output logic               sh_rx,
   output logic [23:0]        sh_addr,
   output logic [7:0]         sh_cmd,
   output logic               cs_n,
   output logic               busy,
   output logic               owner
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;
   typedef enum logic [1:0] {PH_CMD, PH_ADDR, PH_DUMMY, PH_DATA} phase_t;

   localparam int GAP_W = (CS_IDLE_MIN < 2) ? 1 : $clog2(CS_IDLE_MIN + 1);
`ifdef QSPI_SEQ_QUAD_ADDR_EN
   localparam logic QUAD_AD = 1'b1;
`else
   localparam logic QUAD_AD = 1'b0;
`endif

   state_t             state_q, state_d;
   phase_t             phase_q, phase_d, nxt_ph;
   logic [GAP_W-1:0]   gap_q, gap_d;
   logic               last_q, last_d;     // 1 = APB was granted last
   logic               owner_q, owner_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [23:0]        addr_q, addr_d;
   logic               addr_en_q, addr_en_d;
   logic [DUMMY_W-1:0] dummy_q, dummy_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               rd_q, rd_d;
   logic [7:0]         cnt_q, cnt_d;
   logic               quad_q, quad_d, rx_q, rx_d;
   logic               xgnt_q, xgnt_d, agnt_q, agnt_d;
   logic               xdone_q, xdone_d, adone_q, adone_d;
   logic               pick_x, pick_a, start, has_more;

   assign pick_x = xip_req & (~apb_req | last_q);
   assign pick_a = apb_req & (~xip_req | ~last_q);

   // Next phase after the current one, skipping disabled or zero-length phases.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      has_more = 1'b1;
      nxt_ph   = PH_DATA;
      if (phase_q == PH_CMD && (!owner_q || addr_en_q))
         nxt_ph = PH_ADDR;
      else if ((phase_q == PH_CMD || phase_q == PH_ADDR) && dummy_q != '0)
         nxt_ph = PH_DUMMY;
      else if (phase_q != PH_DATA && len_q != '0)
         nxt_ph = PH_DATA;
      else
         has_more = 1'b0;
   end

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      gap_d     = gap_q;
      last_d    = last_q;
      owner_d   = owner_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      addr_en_d = addr_en_q;
      dummy_d   = dummy_q;
      len_d     = len_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      quad_d    = quad_q;
      rx_d      = rx_q;
      xgnt_d    = 1'b0;
      agnt_d    = 1'b0;
      xdone_d   = 1'b0;
      adone_d   = 1'b0;
      start     = 1'b0;

      case (state_q)
         S_IDLE:  start = pick_x | pick_a;
         S_ISSUE: if (sh_ready) state_d = S_WAIT;
         S_WAIT: begin
            if (sh_done) begin
               if (has_more) begin
                  state_d = S_ISSUE;
                  phase_d = nxt_ph;
                  rx_d    = 1'b0;
                  case (nxt_ph)
                     PH_ADDR:  begin cnt_d = 8'd24;         quad_d = ~owner_q & QUAD_AD; end
                     PH_DUMMY: begin cnt_d = 8'(dummy_q);   quad_d = ~owner_q & QUAD_AD; end
                     PH_DATA:  begin cnt_d = 8'(len_q);     quad_d = ~owner_q; rx_d = rd_q; end
                     default:  begin cnt_d = 8'd8;          quad_d = 1'b0; end
                  endcase
               end else begin
                  state_d = S_GAP;
                  gap_d   = GAP_W'(CS_IDLE_MIN);
                  xdone_d = ~owner_q;
                  adone_d = owner_q;
               end
            end
         end
         S_GAP: begin
            // Arbitrate in the final deselect cycle so back-to-back gaps are exact.
            if (gap_q == GAP_W'(1)) begin
               start = pick_x | pick_a;
               if (!(pick_x | pick_a)) state_d = S_IDLE;
            end else begin
               gap_d = gap_q - GAP_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start) begin
         state_d = S_ISSUE;
         owner_d = pick_a;
         last_d  = pick_a;
         xgnt_d  = pick_x;
         agnt_d  = pick_a;
         phase_d = PH_CMD;
         cnt_d   = 8'd8;
         quad_d  = 1'b0;
         rx_d    = 1'b0;
         if (pick_a) begin
            cmd_d = apb_cmd;    addr_d = apb_addr; addr_en_d = apb_addr_en;
            dummy_d = apb_dummy; len_d = apb_len;  rd_d = apb_rd;
         end else begin
            cmd_d = xip_opcode;  addr_d = xip_addr; addr_en_d = 1'b1;
            dummy_d = xip_dummy; len_d = xip_len;   rd_d = 1'b1;
         end
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_CMD;
         gap_q     <= '0;
         last_q    <= 1'b1;
         owner_q   <= 1'b0;
         cmd_q     <= '0;
         addr_q    <= '0;
         addr_en_q <= 1'b0;
         dummy_q   <= '0;
         len_q     <= '0;
         rd_q      <= 1'b0;
         cnt_q     <= '0;
         quad_q    <= 1'b0;
         rx_q      <= 1'b0;
         xgnt_q    <= 1'b0;
         agnt_q    <= 1'b0;
         xdone_q   <= 1'b0;
         adone_q   <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so all flops update together.
         state_q   <= state_d;
         phase_q   <= phase_d;
         gap_q     <= gap_d;
         last_q    <= last_d;
         owner_q   <= owner_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         addr_en_q <= addr_en_d;
         dummy_q   <= dummy_d;
         len_q     <= len_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         quad_q    <= quad_d;
         rx_q      <= rx_d;
         xgnt_q    <= xgnt_d;
         agnt_q    <= agnt_d;
         xdone_q   <= xdone_d;
         adone_q   <= adone_d;
      end
   end

   assign busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
   assign cs_n     = ~busy;
   assign sh_valid = (state_q == S_ISSUE);
   assign sh_phase = phase_q;
   assign sh_cnt   = cnt_q;
   assign sh_quad  = quad_q;
   assign sh_rx    = rx_q;
   assign sh_addr  = addr_q;
   assign sh_cmd   = cmd_q;
   assign owner    = owner_q;
   assign xip_gnt  = xgnt_q;
   assign apb_gnt  = agnt_q;
   assign xip_done = xdone_q;
   assign apb_done = adone_q;

endmodule

// File: tb/tb_quad_spi_seq_arb.sv
// Directed bench for quad_spi_seq_arb with a descriptor/grant scoreboard and a shifter responder.
// Expected lane settings follow QSPI_SEQ_QUAD_ADDR_EN when the bench is built with it.
module tb_quad_spi_seq_arb;

   typedef struct packed {
      logic [1:0]  ph;
      logic [7:0]  cnt;
      logic        quad;
      logic        rx;
      logic [7:0]  cmd;
      logic [23:0] addr;
   } desc_t;

`ifdef QSPI_SEQ_QUAD_ADDR_EN
   localparam logic QAD = 1'b1;
`else
   localparam logic QAD = 1'b0;
`endif

   logic        pclk, rst;
   logic        xip_req, apb_req, apb_addr_en, apb_rd;
   logic [23:0] xip_addr, apb_addr;
   logic [5:0]  xip_len, apb_len;
   logic [7:0]  xip_opcode, apb_cmd;
   logic [3:0]  xip_dummy, apb_dummy;
   logic        xip_gnt, xip_done, apb_gnt, apb_done;
   logic        sh_valid, sh_ready, sh_done, sh_quad, sh_rx;
   logic [1:0]  sh_phase;
   logic [7:0]  sh_cnt, sh_cmd;
   logic [23:0] sh_addr;
   logic        cs_n, busy, owner;

   desc_t exp_q[$];
   logic  gnt_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    x_done_n = 0;
   int    a_done_n = 0;
   int    dly = 0;
   logic  stray_done = 1'b0;

   quad_spi_seq_arb #(.CS_IDLE_MIN(2), .DUMMY_W(4), .LEN_W(6)) dut (
      .pclk(pclk), .rst(rst),
      .xip_req(xip_req), .xip_addr(xip_addr), .xip_len(xip_len),
      .xip_opcode(xip_opcode), .xip_dummy(xip_dummy),
      .xip_gnt(xip_gnt), .xip_done(xip_done),
      .apb_req(apb_req), .apb_cmd(apb_cmd), .apb_addr(apb_addr),
      .apb_addr_en(apb_addr_en), .apb_dummy(apb_dummy), .apb_len(apb_len),
      .apb_rd(apb_rd), .apb_gnt(apb_gnt), .apb_done(apb_done),
      .sh_valid(sh_valid), .sh_ready(sh_ready), .sh_done(sh_done),
      .sh_phase(sh_phase), .sh_cnt(sh_cnt), .sh_quad(sh_quad), .sh_rx(sh_rx),
      .sh_addr(sh_addr), .sh_cmd(sh_cmd),
      .cs_n(cs_n), .busy(busy), .owner(owner)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Shifter model: accepts whenever sh_ready is high, pulses sh_done two cycles after acceptance.
   initial begin
      sh_done = 1'b0;
      forever begin
         @(negedge pclk);
         #1;
         sh_done = 1'b0;
         if (dly > 0) begin
            dly--;
            if (dly == 0) sh_done = 1'b1;
         end
         if (stray_done) begin
            sh_done    = 1'b1;
            stray_done = 1'b0;
         end
         if (sh_valid && sh_ready) dly = 2;
      end
   end

   // Scoreboard monitor: descriptors on handshake, grants on pulse, done pulse counts.
   initial begin
      forever begin
         @(negedge pclk);
         #1;
         if (sh_valid && sh_ready) begin
            if (exp_q.size() == 0)
               check("desc_unexpected", {sh_phase, sh_cnt}, 10'h3FF);
            else
               check("desc", {sh_phase, sh_cnt, sh_quad, sh_rx, sh_cmd, sh_addr}, exp_q.pop_front());
         end
         if (xip_gnt || apb_gnt) begin
            if (gnt_q.size() == 0)
               check("gnt_unexpected", {apb_gnt, xip_gnt}, 2'b00);
            else begin
               logic who;
               who = gnt_q.pop_front();
               check("gnt_vec", {apb_gnt, xip_gnt}, who ? 2'b10 : 2'b01);
               check("gnt_owner_busy", {owner, busy, cs_n}, {who, 1'b1, 1'b0});
            end
         end
         if (xip_done) x_done_n++;
         if (apb_done) a_done_n++;
      end
   end

   task automatic exp_xip(input logic [23:0] a, input logic [5:0] l, input logic [7:0] op,
                          input logic [3:0] d);
      gnt_q.push_back(1'b0);
      exp_q.push_back('{ph: 2'd0, cnt: 8'd8, quad: 1'b0, rx: 1'b0, cmd: op, addr: a});
      exp_q.push_back('{ph: 2'd1, cnt: 8'd24, quad: QAD, rx: 1'b0, cmd: op, addr: a});
      if (d != 0) exp_q.push_back('{ph: 2'd2, cnt: {4'd0, d}, quad: QAD, rx: 1'b0, cmd: op, addr: a});
      if (l != 0) exp_q.push_back('{ph: 2'd3, cnt: {2'd0, l}, quad: 1'b1, rx: 1'b1, cmd: op, addr: a});
   endtask

   task automatic exp_apb(input logic [7:0] c, input logic [23:0] a, input logic aen,
                          input logic [3:0] d, input logic [5:0] l, input logic rd);
      gnt_q.push_back(1'b1);
      exp_q.push_back('{ph: 2'd0, cnt: 8'd8, quad: 1'b0, rx: 1'b0, cmd: c, addr: a});
      if (aen) exp_q.push_back('{ph: 2'd1, cnt: 8'd24, quad: 1'b0, rx: 1'b0, cmd: c, addr: a});
      if (d != 0) exp_q.push_back('{ph: 2'd2, cnt: {4'd0, d}, quad: 1'b0, rx: 1'b0, cmd: c, addr: a});
      if (l != 0) exp_q.push_back('{ph: 2'd3, cnt: {2'd0, l}, quad: 1'b0, rx: rd, cmd: c, addr: a});
   endtask

   task automatic set_xip(input logic [23:0] a, input logic [5:0] l, input logic [7:0] op,
                          input logic [3:0] d);
      xip_addr = a; xip_len = l; xip_opcode = op; xip_dummy = d;
   endtask

   task automatic set_apb(input logic [7:0] c, input logic [23:0] a, input logic aen,
                          input logic [3:0] d, input logic [5:0] l, input logic rd);
      apb_cmd = c; apb_addr = a; apb_addr_en = aen; apb_dummy = d; apb_len = l; apb_rd = rd;
   endtask

   // Returns at the negedge of the cycle that carries a grant pulse.
   task automatic wait_gnt(input string tag);
      int n = 0;
      while (!(xip_gnt || apb_gnt) && n < 300) begin
         @(negedge pclk);
         n++;
      end
      check({tag, "_gnt_wait"}, n < 300, 1'b1);
   endtask

   // From the grant cycle: count cs_n low cycles, then check the done pulse in the first high cycle.
   task automatic count_low(input string tag, input int exp_low, input logic [1:0] exp_vec);
      int low = 1;
      forever begin
         @(negedge pclk);
         if (cs_n || low >= 500) break;
         low++;
      end
      check({tag, "_cs_low"}, low, exp_low);
      check({tag, "_done"}, {apb_done, xip_done}, exp_vec);
   endtask

   task automatic run_txn(input string tag, input int exp_low, input logic [1:0] exp_vec);
      wait_gnt(tag);
      check({tag, "_who"}, {apb_gnt, xip_gnt}, exp_vec);
      if (xip_gnt) xip_req = 1'b0;
      if (apb_gnt) apb_req = 1'b0;
      count_low(tag, exp_low, exp_vec);
   endtask

   initial begin
      int n, hi, xd, ad;
      // NOTE: bench drives inputs with blocking assignments on the negedge, away from the DUT edge.
      rst = 1'b1; xip_req = 1'b0; apb_req = 1'b0; sh_ready = 1'b1;
      set_xip(24'h0, 6'd0, 8'h00, 4'd0);
      set_apb(8'h00, 24'h0, 1'b0, 4'd0, 6'd0, 1'b0);
      repeat (3) @(negedge pclk);
      check("rst_cs_busy_valid", {cs_n, busy, sh_valid}, 3'b100);
      check("rst_pulses_owner", {xip_gnt, apb_gnt, xip_done, apb_done, owner}, 5'b0);
      check("rst_desc", {sh_phase, sh_cnt, sh_quad, sh_rx, sh_cmd, sh_addr}, 44'h0);
      rst = 1'b0;
      @(negedge pclk);

      // XIP quad read
      exp_xip(24'h001234, 6'd4, 8'hEB, 4'd6);
      set_xip(24'h001234, 6'd4, 8'hEB, 4'd6);
      xip_req = 1'b1;
      run_txn("xip1", 12, 2'b01);
      repeat (4) @(negedge pclk);

      // APB WREN, command only
      exp_apb(8'h06, 24'h000000, 1'b0, 4'd0, 6'd0, 1'b0);
      set_apb(8'h06, 24'h000000, 1'b0, 4'd0, 6'd0, 1'b0);
      apb_req = 1'b1;
      run_txn("wren", 3, 2'b10);
      repeat (4) @(negedge pclk);

      // Both requesters held: alternate grants with exact deselect gaps
      exp_xip(24'h100000, 6'd2, 8'h0B, 4'd8);
      exp_apb(8'h9F, 24'h000000, 1'b0, 4'd0, 6'd3, 1'b1);
      exp_xip(24'h100000, 6'd2, 8'h0B, 4'd8);
      exp_apb(8'h9F, 24'h000000, 1'b0, 4'd0, 6'd3, 1'b1);
      set_xip(24'h100000, 6'd2, 8'h0B, 4'd8);
      set_apb(8'h9F, 24'h000000, 1'b0, 4'd0, 6'd3, 1'b1);
      xip_req = 1'b1; apb_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_gnt("tie");
         check("tie_who", {apb_gnt, xip_gnt}, (i % 2) ? 2'b10 : 2'b01);
         if (i == 2) xip_req = 1'b0;
         if (i == 3) apb_req = 1'b0;
         count_low("tie", (i % 2) ? 6 : 12, (i % 2) ? 2'b10 : 2'b01);
         if (i < 3) begin
            hi = 1;
            forever begin
               @(negedge pclk);
               if (!cs_n || hi >= 50) break;
               hi++;
            end
            check("tie_gap", hi, 2);
         end
      end
      repeat (4) @(negedge pclk);

      // Shifter stall during ADDR with a stray sh_done
      exp_xip(24'hABCDEF, 6'd1, 8'h6B, 4'd0);
      set_xip(24'hABCDEF, 6'd1, 8'h6B, 4'd0);
      xip_req = 1'b1;
      wait_gnt("stall");
      xip_req = 1'b0;
      n = 0;
      while (!(sh_valid && sh_phase == 2'd1) && n < 100) begin
         @(negedge pclk);
         n++;
      end
      check("stall_addr_wait", n < 100, 1'b1);
      sh_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("stall_hold", {sh_valid, sh_phase, sh_cnt, sh_addr}, {1'b1, 2'd1, 8'd24, 24'hABCDEF});
         if (k == 1) stray_done = 1'b1;
         @(negedge pclk);
      end
      sh_ready = 1'b1;
      n = 0;
      while (!xip_done && n < 100) begin
         @(negedge pclk);
         n++;
      end
      check("stall_done_wait", n < 100, 1'b1);
      repeat (4) @(negedge pclk);

      // Reset mid-DATA, then a tie after release
      exp_xip(24'h000040, 6'd8, 8'h03, 4'd0);
      set_xip(24'h000040, 6'd8, 8'h03, 4'd0);
      xip_req = 1'b1;
      wait_gnt("rst");
      xip_req = 1'b0;
      n = 0;
      while (!(sh_valid && sh_phase == 2'd3) && n < 100) begin
         @(negedge pclk);
         n++;
      end
      check("rst_data_wait", n < 100, 1'b1);
      xd = x_done_n;
      ad = a_done_n;
      rst = 1'b1;
      #1;
      check("rst_async", {cs_n, sh_valid, busy}, 3'b100);
      exp_q.delete();
      repeat (3) @(negedge pclk);
      check("rst_no_done", {x_done_n, a_done_n}, {xd, ad});
      rst = 1'b0;
      @(negedge pclk);
      exp_xip(24'h000100, 6'd1, 8'h0B, 4'd8);
      exp_apb(8'h02, 24'h00ABCD, 1'b1, 4'd0, 6'd2, 1'b0);
      set_xip(24'h000100, 6'd1, 8'h0B, 4'd8);
      set_apb(8'h02, 24'h00ABCD, 1'b1, 4'd0, 6'd2, 1'b0);
      xip_req = 1'b1; apb_req = 1'b1;
      run_txn("post_rst_x", 12, 2'b01);
      run_txn("post_rst_a", 9, 2'b10);
      repeat (6) @(negedge pclk);

      check("sb_desc_left", exp_q.size(), 0);
      check("sb_gnt_left", gnt_q.size(), 0);
      check("xip_done_total", x_done_n, 5);
      check("apb_done_total", a_done_n, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
